// File: rtl/collector_rr_sweep.sv
// collector_rr_sweep: round-robin reduction engine. Takes a snapshot of one
// value per channel at sweep start and folds the included channels into a
// single sum through an external fixed-latency adder, one channel at a time.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   accum_value             per-channel input values (snapshotted at start)
//   chan_mask               1 = channel included in the sum
//   num_active              channels 0..num_active-1 considered (clamped)
//   start                   one-cycle sweep request (ignored while busy)
//   continuous              1 = restart automatically after every sweep
//   add_dataa / add_datab   adder operands (channel value / partial sum)
//   add_result/add_overflow adder outputs, valid ADD_LATENCY cycles after load
//   result                  last completed sum, held until the next sweep ends
//   result_valid            one-cycle completion pulse
//   result_overflow         OR of add_overflow over the completed sweep
//   busy                    high from sweep start through the DONE cycle
//   sweep_count             completed sweeps, wraps
module collector_rr_sweep #(
    parameter int unsigned NUM_PROCS   = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADD_LATENCY = 7,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PROCS-1:0][DATA_W-1:0]  accum_value,
    input  logic [NUM_PROCS-1:0]              chan_mask,
    input  logic [4:0]                        num_active,
    input  logic                              start,
    input  logic                              continuous,
    output logic [DATA_W-1:0]                 add_dataa,
    output logic [DATA_W-1:0]                 add_datab,
    input  logic [DATA_W-1:0]                 add_result,
    input  logic                              add_overflow,
    output logic [DATA_W-1:0]                 result,
    output logic                              result_valid,
    output logic                              result_overflow,
    output logic                              busy,
    output logic [CNT_W-1:0]                  sweep_count
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SEL_W  = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;
    localparam int unsigned WAIT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADD_LATENCY - 1);
    localparam logic [IDX_W-1:0]  N_MAX     = IDX_W'(NUM_PROCS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                             state_q, state_d;
    logic [NUM_PROCS-1:0][DATA_W-1:0]   snap_q, snap_d;
    logic [NUM_PROCS-1:0]               mask_q, mask_d;
    logic [IDX_W-1:0]                   n_q, n_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [DATA_W-1:0]                  partial_q, partial_d;
    logic                               sticky_q, sticky_d;
    logic [WAIT_W-1:0]                  wait_q, wait_d;
    logic [DATA_W-1:0]                  dataa_q, dataa_d;
    logic [DATA_W-1:0]                  datab_q, datab_d;
    logic [DATA_W-1:0]                  result_q, result_d;
    logic                               valid_q, valid_d;
    logic                               ovf_q, ovf_d;
    logic                               busy_q, busy_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;

    // Channel selector; only used while idx_q < n_q <= NUM_PROCS.
    logic [SEL_W-1:0] sel;
    assign sel = idx_q[SEL_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            mask_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            partial_q <= '0;
            sticky_q  <= 1'b0;
            wait_q    <= '0;
            dataa_q   <= '0;
            datab_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            mask_q    <= mask_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            partial_q <= partial_d;
            sticky_q  <= sticky_d;
            wait_q    <= wait_d;
            dataa_q   <= dataa_d;
            datab_q   <= datab_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        mask_d    = mask_q;
        n_d       = n_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        sticky_d  = sticky_q;
        wait_d    = wait_q;
        dataa_d   = dataa_q;
        datab_d   = datab_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start || continuous) begin
                    snap_d    = accum_value;
                    mask_d    = chan_mask;
                    n_d       = (num_active > N_MAX) ? N_MAX : num_active;
                    partial_d = '0;
                    sticky_d  = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (idx_q >= n_q) begin
                    // Completion is registered on entry so the pulse coincides with DONE.
                    result_d = partial_q;
                    ovf_d    = sticky_q;
                    valid_d  = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = S_DONE;
                end else if (!mask_q[sel]) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    dataa_d = snap_q[sel];
                    datab_d = partial_q;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // wait_q counts edges since operand load; capture on the ADD_LATENCY-th.
                if (wait_q == WAIT_LAST) begin
                    partial_d = add_result;
                    sticky_d  = sticky_q | add_overflow;
                    idx_d     = idx_q + IDX_W'(1);
                    state_d   = S_ISSUE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign add_dataa       = dataa_q;
    assign add_datab       = datab_q;
    assign result          = result_q;
    assign result_valid    = valid_q;
    assign result_overflow = ovf_q;
    assign busy            = busy_q;
    assign sweep_count     = cnt_q;

endmodule

// File: tb/tb_collector_rr_sweep.sv
// Testbench for collector_rr_sweep with an integer adder model
// (ADD_LATENCY=7, overflow = carry-out). Expected sums, overflow, sweep count
// and completion cycle are queued when a sweep is launched and checked when
// result_valid pulses.
module tb_collector_rr_sweep;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AL = 7;
    localparam int unsigned CW = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NP-1:0][DW-1:0]    accum_value;
    logic [NP-1:0]            chan_mask;
    logic [4:0]               num_active;
    logic                     start;
    logic                     continuous;
    logic [DW-1:0]            add_dataa;
    logic [DW-1:0]            add_datab;
    logic [DW-1:0]            add_result;
    logic                     add_overflow;
    logic [DW-1:0]            result;
    logic                     result_valid;
    logic                     result_overflow;
    logic                     busy;
    logic [CW-1:0]            sweep_count;

    collector_rr_sweep #(
        .NUM_PROCS  (NP),
        .DATA_W     (DW),
        .ADD_LATENCY(AL),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .accum_value    (accum_value),
        .chan_mask      (chan_mask),
        .num_active     (num_active),
        .start          (start),
        .continuous     (continuous),
        .add_dataa      (add_dataa),
        .add_datab      (add_datab),
        .add_result     (add_result),
        .add_overflow   (add_overflow),
        .result         (result),
        .result_valid   (result_valid),
        .result_overflow(result_overflow),
        .busy           (busy),
        .sweep_count    (sweep_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Integer adder: sum sampled on the edge ADD_LATENCY edges after the operands change.
    logic [DW:0] pipe [0:AL-2];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_dataa} + {1'b0, add_datab};
        for (int i = 1; i < int'(AL) - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result   = pipe[AL-2][DW-1:0];
    assign add_overflow = pipe[AL-2][DW];

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        logic [CW-1:0] cnt;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;

    // Advance to the next falling edge and score any completion pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && result_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cycle=%0d result=%h", cyc, result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res) begin
                    n_err++;
                    $display("FAIL result got=%h exp=%h", result, e.res);
                end
                n_vec++;
                if (result_overflow !== e.ovf) begin
                    n_err++;
                    $display("FAIL result_overflow got=%b exp=%b", result_overflow, e.ovf);
                end
                n_vec++;
                if (sweep_count !== e.cnt) begin
                    n_err++;
                    $display("FAIL sweep_count got=%0d exp=%0d", sweep_count, e.cnt);
                end
                n_vec++;
                if (cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL pulse_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    endtask

    // Reference reduction; t0c is the cycle number right after the start edge.
    task automatic push_sweep(input logic [NP-1:0][DW-1:0] v, input logic [NP-1:0] m,
                              input int na, input int t0c);
        exp_t        e;
        logic [DW:0] s;
        logic [DW-1:0] acc = '0;
        logic        ovf = 1'b0;
        int          n, a = 0, k = 0;
        n = (na > int'(NP)) ? int'(NP) : na;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                s   = {1'b0, acc} + {1'b0, v[i]};
                acc = s[DW-1:0];
                ovf = ovf | s[DW];
                a++;
            end else begin
                k++;
            end
        end
        exp_cnt++;
        e.res = acc;
        e.ovf = ovf;
        e.cnt = CW'(exp_cnt);
        e.cyc = t0c + a * int'(AL + 1) + k + 1;
        sb.push_back(e);
    endtask

    task automatic start_sweep(input logic [NP-1:0][DW-1:0] v, input logic [NP-1:0] m,
                               input logic [4:0] na, output int t0c);
        tick();
        accum_value = v;
        chan_mask   = m;
        num_active  = na;
        start       = 1'b1;
        t0c         = cyc + 1;
        push_sweep(v, m, int'(na), t0c);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({result, result_valid, result_overflow, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0", result, result_valid,
                     result_overflow, busy);
        end
        n_vec++;
        if (sweep_count !== '0) begin
            n_err++;
            $display("FAIL reset_count got=%0d exp=0", sweep_count);
        end
        n_vec++;
        if ({add_dataa, add_datab} !== '0) begin
            n_err++;
            $display("FAIL reset_operands got=%h/%h exp=0", add_dataa, add_datab);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_sum();
        int t0;
        start_sweep({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 5'd4, t0);
        drain(100);
        repeat (5) tick();
        n_vec++;
        if (result !== 32'd10) begin
            n_err++;
            $display("FAIL result_hold got=%h exp=%h", result, 32'd10);
        end
    endtask

    task automatic test_masked();
        int t0;
        start_sweep({32'd4, 32'd3, 32'd2, 32'd1}, 4'b1010, 5'd4, t0);
        drain(100);
    endtask

    task automatic test_num_active();
        int t0;
        start_sweep({32'd11, 32'd9, 32'd7, 32'd5}, 4'hF, 5'd2, t0);
        drain(100);
        start_sweep({32'd11, 32'd9, 32'd7, 32'd5}, 4'hF, 5'd9, t0);
        drain(100);
    endtask

    task automatic test_start_while_busy();
        int   t0;
        logic busy_ok = 1'b1;
        start_sweep({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 5'd4, t0);
        for (int i = 0; i < 100; i++) begin
            if (cyc == t0 + 2) begin
                accum_value = {32'd100, 32'd100, 32'd100, 32'd100};
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (sb.size() == 0) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
        end
        start = 1'b0;
        n_vec++;
        if (busy_ok !== 1'b1) begin
            n_err++;
            $display("FAIL busy_continuous got=0 exp=1");
        end
        drain(10);
        repeat (3) tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_overflow();
        int t0;
        start_sweep({32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, 4'hF, 5'd4, t0);
        drain(100);
        start_sweep({32'd1, 32'd1, 32'd1, 32'd1}, 4'hF, 5'd4, t0);
        drain(100);
    endtask

    task automatic test_continuous();
        int t0;
        tick();
        accum_value = {32'd4, 32'd3, 32'd2, 32'd1};
        chan_mask   = 4'hF;
        num_active  = 5'd4;
        continuous  = 1'b1;
        t0          = cyc + 1;
        // Back-to-back sweeps: DONE cycle plus one IDLE cycle between them.
        for (int s = 0; s < 3; s++) push_sweep(accum_value, chan_mask, 4, t0 + s * 35);
        // Fourth sweep starts at t0+105; reset lands on its edge T0+10.
        for (int i = 0; i < 200; i++) begin
            if (cyc >= t0 + 105 + 9) break;
            tick();
        end
        reset      = 1'b1;
        continuous = 1'b0;
        tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL continuous_pulses pending=%0d exp=0", sb.size());
            sb.delete();
        end
        n_vec++;
        if ({result, result_valid, result_overflow, busy, sweep_count} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs got=%h/%b/%b/%b/%0d exp=0", result, result_valid,
                     result_overflow, busy, sweep_count);
        end
        exp_cnt = 0;
        reset   = 1'b0;
        tick();
        start_sweep({32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 5'd0, t0);
        drain(20);
    endtask

    initial begin
        reset       = 1'b1;
        accum_value = '0;
        chan_mask   = '0;
        num_active  = '0;
        start       = 1'b0;
        continuous  = 1'b0;
        test_reset();
        test_full_sum();
        test_masked();
        test_num_active();
        test_start_while_busy();
        test_overflow();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
